bram_stream_reader: RTL

Read-side streaming engine that sits directly downstream of a simple dual-port BRAM's registered read port. On a start command it walks a contiguous address range, drives the BRAM read address/enable, absorbs the one-cycle BRAM read latency, and presents the words on a valid/ready stream with a last flag. A 2-entry output buffer plus in-flight credit accounting gives full throughput with no word loss under arbitrary backpressure.

---
 rtl/bram_stream_reader.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/bram_stream_reader.sv
// bram_stream_reader
// Walks a contiguous BRAM address range on a start command, absorbs the
// one-cycle registered read latency and presents the words on a
// valid/ready stream with a last flag. A 2-entry output buffer plus
// in-flight credit accounting keeps full throughput under backpressure.
module bram_stream_reader #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic [RAM_ADDR_BITS-1:0] base_addr_i,
    input  logic [RAM_ADDR_BITS:0]   len_i,
    output logic [RAM_ADDR_BITS-1:0] ram_addr_o,
    output logic                     ram_en_o,
    input  logic [RAM_WIDTH-1:0]     ram_data_i,
    output logic [RAM_WIDTH-1:0]     m_data_o,
    output logic                     m_valid_o,
    output logic                     m_last_o,
    input  logic                     m_ready_i,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]                     state_q, state_d;
    logic [RAM_ADDR_BITS-1:0]       addr_q, addr_d;
    logic [RAM_ADDR_BITS:0]         rem_q, rem_d;
    logic                           done_q, done_d;
    logic                           inflight_q;
    logic                           inflight_last_q;
    logic [1:0][RAM_WIDTH-1:0]      buf_data_q;
    logic [1:0]                     buf_last_q;
    logic                           wr_ptr_q;
    logic                           rd_ptr_q;
    logic [1:0]                     occ_q;

    logic                           issue_s;
    logic                           pop_s;
    logic                           head_last_s;
    logic                           start_run_s;
    logic                           start_zero_s;
    logic                           rem_one_s;

    assign pop_s        = (occ_q != 2'd0) & m_ready_i;
    assign head_last_s  = buf_last_q[rd_ptr_q];
    assign start_run_s  = (state_q == S_IDLE) & start_i & (len_i != {(RAM_ADDR_BITS+1){1'b0}});
    assign start_zero_s = (state_q == S_IDLE) & start_i & (len_i == {(RAM_ADDR_BITS+1){1'b0}});
    assign rem_one_s    = (rem_q == {{RAM_ADDR_BITS{1'b0}}, 1'b1});

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: RUN until the last read is issued, DRAIN until the last beat leaves
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_run_s) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (issue_s && rem_one_s) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (pop_s && head_last_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output/control logic: read issue credit check, address/count update, done pulse
    always_comb begin
        issue_s = 1'b0;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_run_s) begin
                    addr_d = base_addr_i;
                    rem_d  = len_i;
                end else begin
                    addr_d = addr_q;
                    rem_d  = rem_q;
                end
                done_d = start_zero_s;
            end
            S_RUN: begin
                // Buffered words plus the one in flight must fit once this read lands.
                issue_s = (rem_q != {(RAM_ADDR_BITS+1){1'b0}}) &&
                          (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_s}));
                if (issue_s) begin
                    addr_d = addr_q + {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};
                    rem_d  = rem_q - {{RAM_ADDR_BITS{1'b0}}, 1'b1};
                end else begin
                    addr_d = addr_q;
                    rem_d  = rem_q;
                end
            end
            S_DRAIN: begin
                done_d = pop_s & head_last_s;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Address counter, remaining count and done pulse registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q <= {RAM_ADDR_BITS{1'b0}};
            rem_q  <= {(RAM_ADDR_BITS+1){1'b0}};
            done_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            done_q <= done_d;
        end
    end

    // In-flight tracking and 2-entry output buffer; a landing read is always written
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            buf_data_q      <= '0;
            buf_last_q      <= 2'b00;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            occ_q           <= 2'd0;
        end else begin
            inflight_q      <= issue_s;
            inflight_last_q <= issue_s & rem_one_s;
            if (inflight_q) begin
                buf_data_q[wr_ptr_q] <= ram_data_i;
                buf_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop_s};
        end
    end

    assign ram_addr_o = addr_q;
    assign ram_en_o   = issue_s;
    assign m_valid_o  = (occ_q != 2'd0);
    assign m_data_o   = buf_data_q[rd_ptr_q];
    assign m_last_o   = m_valid_o & head_last_s;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;

endmodule
